// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage: occupancy encoding and
// default widths/bubble instruction used when a stage is instantiated without overrides.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occState_t;

    localparam int          DEFAULT_DATA_W = 32;
    localparam logic [31:0] DEFAULT_NOP_IR = 32'h0000_0000;

endpackage

// File: rtl/pipe_slot.sv
// One holding register of the elastic stage: payload plus valid flag.
// kill beats load, and load beats drain, so a slot can be refilled in the same cycle it empties.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int W = DEFAULT_DATA_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         kill,
    input  logic         load,
    input  logic         drain,
    input  logic [W-1:0] dIn,
    output logic [W-1:0] dOut,
    output logic         valid
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            dOut  <= '0;
        end else if (kill) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            dOut  <= dIn;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic stage boundary register: valid/ready handshake with a main slot and a skid slot,
// synchronous flush that injects a bubble, and a saturating back-pressure counter.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = DEFAULT_DATA_W,
    parameter int                NUM_DATA = 3,
    parameter logic [DATA_W-1:0] NOP_IR   = DATA_W'(DEFAULT_NOP_IR)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_pc,
    input  logic [DATA_W-1:0]          in_ir,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_pc,
    output logic [DATA_W-1:0]          out_ir,
    output logic [NUM_DATA*DATA_W-1:0] out_data,
    output logic [15:0]                stall_cnt
);

    localparam int PAY_W = (2 + NUM_DATA) * DATA_W;

    occState_t state;

    logic                       inFire, outFire;
    logic                       mainLoad, skidLoad, skidDrain;
    logic                       mainValid, skidValid;
    logic [PAY_W-1:0]           inPayload, mainIn, mainPayload, skidPayload;
    logic [DATA_W-1:0]          headPc, headIr;
    logic [NUM_DATA*DATA_W-1:0] headData;

    // in_ready decodes only the state flop, so it never depends on out_ready.
    assign in_ready  = (state != TWO);
    assign inFire    = in_valid & in_ready;
    assign outFire   = mainValid & out_ready;
    assign inPayload = {in_pc, in_ir, in_data};

    // The skid entry is always older than anything arriving, so it refills main first.
    assign mainIn    = skidValid ? skidPayload : inPayload;
    assign mainLoad  = ((state == EMPTY) & inFire)
                     | ((state == ONE) & inFire & outFire)
                     | ((state == TWO) & outFire);
    assign skidLoad  = (state == ONE) & inFire & ~outFire;
    assign skidDrain = (state == TWO) & outFire;

    pipe_slot #(.W(PAY_W)) mainSlot (
        .clock (clock),
        .reset (reset),
        .kill  (flush),
        .load  (mainLoad),
        .drain (outFire),
        .dIn   (mainIn),
        .dOut  (mainPayload),
        .valid (mainValid)
    );

    pipe_slot #(.W(PAY_W)) skidSlot (
        .clock (clock),
        .reset (reset),
        .kill  (flush),
        .load  (skidLoad),
        .drain (skidDrain),
        .dIn   (inPayload),
        .dOut  (skidPayload),
        .valid (skidValid)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY:   if (inFire) state <= ONE;
                ONE: begin
                    if (inFire && !outFire)      state <= TWO;
                    else if (!inFire && outFire) state <= EMPTY;
                end
                TWO:     if (outFire) state <= ONE;
                default: state <= EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt <= 16'h0000;
        end else if (mainValid && !out_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'h0001;
        end
    end

    assign {headPc, headIr, headData} = mainPayload;
    assign out_valid = mainValid;
    assign out_pc    = mainValid ? headPc   : '0;
    assign out_ir    = mainValid ? headIr   : NOP_IR;
    assign out_data  = mainValid ? headData : '0;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed and scoreboard checks for pipe_stage_elastic: a wide stage with a non-zero bubble
// instruction and a narrow single-word stage sharing clock and reset.
module tb_pipe_stage_elastic;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    always #5 clock = ~clock;

    logic        flush = 1'b0, inValid = 1'b0, outReady = 1'b0;
    logic        inReady, outValid;
    logic [31:0] inPc = '0, inIr = '0, outPc, outIr;
    logic [95:0] inData = '0, outData;
    logic [15:0] stallCnt;

    logic        sFlush = 1'b0, sInValid = 1'b0, sOutReady = 1'b0;
    logic        sInReady, sOutValid;
    logic [15:0] sInPc = '0, sInIr = '0, sInData = '0, sOutPc, sOutIr, sOutData, sStall;

    int vectors = 0;
    int miscompares = 0;

    pipe_stage_elastic #(.DATA_W(32), .NUM_DATA(3), .NOP_IR(NOP)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(inValid), .in_ready(inReady), .in_pc(inPc), .in_ir(inIr), .in_data(inData),
        .out_valid(outValid), .out_ready(outReady), .out_pc(outPc), .out_ir(outIr),
        .out_data(outData), .stall_cnt(stallCnt)
    );

    pipe_stage_elastic #(.DATA_W(16), .NUM_DATA(1)) dutNarrow (
        .clock(clock), .reset(reset), .flush(sFlush),
        .in_valid(sInValid), .in_ready(sInReady), .in_pc(sInPc), .in_ir(sInIr), .in_data(sInData),
        .out_valid(sOutValid), .out_ready(sOutReady), .out_pc(sOutPc), .out_ir(sOutIr),
        .out_data(sOutData), .stall_cnt(sStall)
    );

    function automatic logic [95:0] makeData(input logic [31:0] pc);
        return {32'hC000_0000 | pc, 32'hB000_0000 | pc, 32'hA000_0000 | pc};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc);
        inValid = 1'b1;
        inPc    = pc;
        inIr    = 32'hE000_0000 | pc;
        inData  = makeData(pc);
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({outValid, inReady, outPc, outIr, outData, stallCnt} !== {1'b0, 1'b1, 32'h0, NOP, 96'h0, 16'h0}) begin
            miscompares++;
            $display("[TB] FAIL reset_values: got valid=%b ready=%b pc=%h ir=%h stall=%h, expected 0 1 0 %h 0",
                     outValid, inReady, outPc, outIr, stallCnt, NOP);
        end
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        logic [31:0] pc;
        outReady = 1'b1;
        for (int i = 0; i < 9; i++) begin
            pc = 32'h100 + 32'(4 * i);
            if (i < 8) drive(pc);
            else inValid = 1'b0;
            tick();
            vectors++;
            if (inReady !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL stream_in_ready[%0d]: got %b expected 1", i, inReady);
            end
            vectors++;
            if (i < 8) begin
                if ({outValid, outPc, outIr, outData} !== {1'b1, pc, 32'hE000_0000 | pc, makeData(pc)}) begin
                    miscompares++;
                    $display("[TB] FAIL stream_out[%0d]: got valid=%b pc=%h ir=%h expected valid=1 pc=%h", i, outValid, outPc, outIr, pc);
                end
            end else if ({outValid, outIr} !== {1'b0, NOP}) begin
                miscompares++;
                $display("[TB] FAIL stream_drained: got valid=%b ir=%h expected 0 %h", outValid, outIr, NOP);
            end
        end
    endtask

    task automatic test_back_pressure();
        outReady = 1'b0;
        drive(32'h200);
        tick();
        drive(32'h204);
        tick();
        inValid = 1'b0;
        vectors++;
        if ({inReady, outValid, outPc, stallCnt} !== {1'b0, 1'b1, 32'h200, 16'd1}) begin
            miscompares++;
            $display("[TB] FAIL bp_full: got ready=%b valid=%b pc=%h stall=%0d expected 0 1 200 1", inReady, outValid, outPc, stallCnt);
        end
        repeat (3) tick();
        vectors++;
        if ({outPc, stallCnt} !== {32'h200, 16'd4}) begin
            miscompares++;
            $display("[TB] FAIL bp_hold: got pc=%h stall=%0d expected 200 4", outPc, stallCnt);
        end
        outReady = 1'b1;
        tick();
        vectors++;
        if ({outValid, outPc, inReady, stallCnt} !== {1'b1, 32'h204, 1'b1, 16'd4}) begin
            miscompares++;
            $display("[TB] FAIL bp_second: got valid=%b pc=%h ready=%b stall=%0d expected 1 204 1 4", outValid, outPc, inReady, stallCnt);
        end
        tick();
        vectors++;
        if ({outValid, outIr} !== {1'b0, NOP}) begin
            miscompares++;
            $display("[TB] FAIL bp_empty: got valid=%b ir=%h expected 0 %h", outValid, outIr, NOP);
        end
    endtask

    task automatic test_flush();
        outReady = 1'b0;
        drive(32'h300);
        tick();
        drive(32'h304);
        tick();
        drive(32'h308);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        inValid = 1'b0;
        vectors++;
        if ({outValid, outIr, outPc, outData, inReady} !== {1'b0, NOP, 32'h0, 96'h0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL flush_two: got valid=%b ir=%h pc=%h ready=%b expected 0 %h 0 1", outValid, outIr, outPc, inReady, NOP);
        end
        vectors++;
        if (stallCnt != 16'd5 && stallCnt != 16'd6) begin
            miscompares++;
            $display("[TB] FAIL flush_stall_kept: got %0d expected 5 or 6", stallCnt);
        end
        outReady = 1'b1;
        tick();
        vectors++;
        if (outValid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_no_leak: got valid=%b pc=%h expected valid 0", outValid, outPc);
        end
        outReady = 1'b0;
        drive(32'h310);
        tick();
        drive(32'h314);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        inValid = 1'b0;
        outReady = 1'b1;
        tick();
        vectors++;
        if ({outValid, outIr} !== {1'b0, NOP}) begin
            miscompares++;
            $display("[TB] FAIL flush_one: got valid=%b pc=%h expected valid 0", outValid, outPc);
        end
    endtask

    task automatic test_async_reset();
        outReady = 1'b1;
        drive(32'h400);
        tick();
        drive(32'h404);
        tick();
        #3 reset = 1'b0;
        inValid = 1'b0;
        #1;
        vectors++;
        if ({outValid, inReady, outPc, outIr, outData, stallCnt} !== {1'b0, 1'b1, 32'h0, NOP, 96'h0, 16'h0}) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got valid=%b ready=%b pc=%h ir=%h stall=%h expected 0 1 0 %h 0",
                     outValid, inReady, outPc, outIr, stallCnt, NOP);
        end
        @(negedge clock) reset = 1'b1;
        tick();
        drive(32'h410);
        tick();
        inValid = 1'b0;
        vectors++;
        if ({outValid, outPc} !== {1'b1, 32'h410}) begin
            miscompares++;
            $display("[TB] FAIL post_reset_entry: got valid=%b pc=%h expected 1 410", outValid, outPc);
        end
        tick();
    endtask

    task automatic test_saturation();
        outReady = 1'b0;
        drive(32'h500);
        tick();
        inValid = 1'b0;
        repeat (65534) @(posedge clock);
        #1;
        vectors++;
        if (stallCnt !== 16'hFFFE) begin
            miscompares++;
            $display("[TB] FAIL sat_before: got %h expected FFFE", stallCnt);
        end
        tick();
        vectors++;
        if (stallCnt !== 16'hFFFF) begin
            miscompares++;
            $display("[TB] FAIL sat_reach: got %h expected FFFF", stallCnt);
        end
        repeat (4465) @(posedge clock);
        #1;
        vectors++;
        if ({stallCnt, outPc} !== {16'hFFFF, 32'h500}) begin
            miscompares++;
            $display("[TB] FAIL sat_hold: got stall=%h pc=%h expected FFFF 500", stallCnt, outPc);
        end
        outReady = 1'b1;
        tick();
    endtask

    task automatic test_narrow();
        logic [47:0] q[$];
        logic [50:0] expected, observed;
        logic        willIn, willOut;
        sOutReady = 1'b0;
        sInValid  = 1'b1;
        sInPc     = 16'h0010;
        sInIr     = 16'h1234;
        sInData   = 16'hBEEF;
        tick();
        sInValid  = 1'b0;
        sOutReady = 1'b1;
        vectors++;
        if ({sOutValid, sOutData, sOutPc, sOutIr} !== {1'b1, 16'hBEEF, 16'h0010, 16'h1234}) begin
            miscompares++;
            $display("[TB] FAIL narrow_beef: got valid=%b data=%h pc=%h ir=%h expected 1 beef 0010 1234", sOutValid, sOutData, sOutPc, sOutIr);
        end
        tick();
        vectors++;
        if ({sOutValid, sOutIr, sStall} !== {1'b0, 16'h0, 16'h0}) begin
            miscompares++;
            $display("[TB] FAIL narrow_drain: got valid=%b ir=%h stall=%0d expected 0 0 0", sOutValid, sOutIr, sStall);
        end
        for (int c = 0; c < 10000; c++) begin
            if (q.size() == 0) expected = {1'b0, 48'h0, 1'b1, 1'b0};
            else expected = {1'b1, q[0], (q.size() < 2), 1'b0};
            observed = {sOutValid, sOutPc, sOutIr, sOutData, sInReady, 1'b0};
            vectors++;
            if (observed !== expected) begin
                miscompares++;
                $display("[TB] FAIL narrow_scoreboard[%0d]: got %h expected %h", c, observed, expected);
            end
            sInValid  = ($urandom_range(0, 9) < 6);
            sOutReady = ($urandom_range(0, 9) < 6);
            sInPc     = 16'($urandom);
            sInIr     = 16'($urandom);
            sInData   = 16'($urandom);
            willIn    = sInValid && (q.size() < 2);
            willOut   = (q.size() != 0) && sOutReady;
            tick();
            if (willOut) void'(q.pop_front());
            if (willIn) q.push_back({sInPc, sInIr, sInData});
        end
        sInValid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_pressure();
        test_flush();
        test_async_reset();
        test_saturation();
        test_narrow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
